// File: rtl/regcontent_pkg.sv
// regcontent_pkg
//   Shared definitions for the register-content read sequencer:
//   - state_e        : sequencer FSM states (IDLE, REQ)
//   - ADDR_*         : Avalon-MM word addresses of the four host registers
//   - CTRL_* / STATUS_* / IEN_* : bit positions inside those registers
package regcontent_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_e;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_CTRL   = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;
   localparam logic [1:0] ADDR_IEN    = 2'd3;

   localparam int CTRL_START_BIT   = 31;
   localparam int CTRL_AUTO_BIT    = 30;

   localparam int STATUS_BUSY_BIT  = 0;
   localparam int STATUS_VALID_BIT = 1;
   localparam int STATUS_TERR_BIT  = 2;
   localparam int STATUS_SEQ_LSB   = 16;

   localparam int IEN_EN_BIT       = 0;

endpackage

// File: rtl/regcontent_timeout_cnt.sv
// regcontent_timeout_cnt
//   Counts the cycles the sequencer spends in REQ and flags the cycle in
//   which the TIMEOUT-th REQ cycle is running, so the sequencer can abort
//   on that edge.
// Ports:
//   clk      in  clock
//   reset_n  in  asynchronous, active-low reset
//   clr      in  hold the count at zero (sequencer idle)
//   en       in  sequencer is in REQ this cycle
//   expired  out this is the TIMEOUT-th REQ cycle (combinational from the count)
module regcontent_timeout_cnt #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // cnt_q holds the number of REQ cycles already completed, so the current
   // cycle is number cnt_q+1; reaching TIMEOUT means cnt_q == TIMEOUT-1.
   assign expired = en && (cnt_q == CNT_W'(TIMEOUT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && !expired) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/regcontent_read_sequencer.sv
// regcontent_read_sequencer
//   Host-facing snapshot reader for a fabric register file. The host writes
//   an index with the start bit set; the block raises rf_req until rf_ack
//   (capturing rf_data) or until TIMEOUT REQ cycles elapse, then the host
//   reads one coherent captured word from DATA.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   avs_address/read/write/
//   avs_writedata/avs_readdata    Avalon-MM slave, 1-cycle registered read
//   rf_req, rf_idx                register-file request (level) and index
//   rf_ack, rf_data               one-cycle acknowledge with data
//   irq                           level interrupt, registered
// Configuration:
//   REGCONTENT_AUTO_SCAN_EN  when defined, CTRL[30] enables auto-scan:
//                            each finished transfer bumps the index and a new
//                            request starts after one idle cycle.
module regcontent_read_sequencer #(
   parameter int IDX_W   = 6,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   output logic [31:0]       avs_readdata,
   output logic              rf_req,
   output logic [IDX_W-1:0]  rf_idx,
   input  logic              rf_ack,
   input  logic [DATA_W-1:0] rf_data,
   output logic              irq
);
   import regcontent_pkg::*;

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [31:0]       data_q, data_d;
   logic              valid_q, valid_d;
   logic              terr_q, terr_d;
   logic [7:0]        seq_q, seq_d;
   logic              ien_q, ien_d;
   logic              irq_q, irq_d;
   logic              rf_req_q, rf_req_d;
   logic [31:0]       rdata_q, rdata_d;
`ifdef REGCONTENT_AUTO_SCAN_EN
   logic              auto_q, auto_d;
   logic              relaunch_q, relaunch_d;
`endif

   logic        busy;
   logic        expired;
   logic        wr_ctrl, wr_status, wr_ien;
   logic [31:0] ctrl_rd, status_rd;
   logic        unused_wd;

   assign busy      = (state_q == REQ);
   assign wr_ctrl   = avs_write && (avs_address == ADDR_CTRL);
   assign wr_status = avs_write && (avs_address == ADDR_STATUS);
   assign wr_ien    = avs_write && (avs_address == ADDR_IEN);
   assign unused_wd = ^avs_writedata;

   regcontent_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (!busy),
      .en      (busy),
      .expired (expired)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      data_d    = data_q;
      valid_d   = valid_q;
      terr_d    = terr_q;
      seq_d     = seq_q;
      ien_d     = ien_q;
      rdata_d   = rdata_q;
      ctrl_rd   = '0;
      status_rd = '0;
`ifdef REGCONTENT_AUTO_SCAN_EN
      auto_d     = auto_q;
      relaunch_d = 1'b0;
`endif

      if (wr_ien) begin
         ien_d = avs_writedata[IEN_EN_BIT];
      end
      // W1C clears come first so that a capture or timeout below overrides them.
      if (wr_status) begin
         if (avs_writedata[STATUS_VALID_BIT]) valid_d = 1'b0;
         if (avs_writedata[STATUS_TERR_BIT])  terr_d  = 1'b0;
      end
`ifdef REGCONTENT_AUTO_SCAN_EN
      // auto stays writable while busy so a scan can be stopped mid-transfer.
      if (wr_ctrl) begin
         auto_d = avs_writedata[CTRL_AUTO_BIT];
      end
`endif

      case (state_q)
         IDLE: begin
            if (wr_ctrl) begin
               idx_d = avs_writedata[IDX_W-1:0];
               if (avs_writedata[CTRL_START_BIT]) begin
                  state_d = REQ;
                  valid_d = 1'b0;
                  terr_d  = 1'b0;
               end
            end
`ifdef REGCONTENT_AUTO_SCAN_EN
            if (relaunch_q && auto_d) begin
               state_d = REQ;
            end
`endif
         end
         REQ: begin
            // Ack has priority over the timeout in the same cycle.
            if (rf_ack) begin
               data_d  = 32'(rf_data);
               valid_d = 1'b1;
               seq_d   = seq_q + 8'd1;
               state_d = IDLE;
            end else if (expired) begin
               terr_d  = 1'b1;
               state_d = IDLE;
            end
`ifdef REGCONTENT_AUTO_SCAN_EN
            if ((rf_ack || expired) && auto_d) begin
               idx_d      = idx_q + 1'b1;
               relaunch_d = 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase

      rf_req_d = (state_d == REQ);
      irq_d    = ien_q & (valid_q | terr_q);

      ctrl_rd[IDX_W-1:0] = idx_q;
`ifdef REGCONTENT_AUTO_SCAN_EN
      ctrl_rd[CTRL_AUTO_BIT] = auto_q;
`endif
      status_rd[STATUS_BUSY_BIT]        = busy;
      status_rd[STATUS_VALID_BIT]       = valid_q;
      status_rd[STATUS_TERR_BIT]        = terr_q;
      status_rd[STATUS_SEQ_LSB +: 8]    = seq_q;

      if (avs_read) begin
         case (avs_address)
            ADDR_DATA:   rdata_d = data_q;
            ADDR_CTRL:   rdata_d = ctrl_rd;
            ADDR_STATUS: rdata_d = status_rd;
            default:     rdata_d = {31'd0, ien_q};
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         terr_q     <= 1'b0;
         seq_q      <= '0;
         ien_q      <= 1'b0;
         irq_q      <= 1'b0;
         rf_req_q   <= 1'b0;
         rdata_q    <= '0;
`ifdef REGCONTENT_AUTO_SCAN_EN
         auto_q     <= 1'b0;
         relaunch_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         terr_q     <= terr_d;
         seq_q      <= seq_d;
         ien_q      <= ien_d;
         irq_q      <= irq_d;
         rf_req_q   <= rf_req_d;
         rdata_q    <= rdata_d;
`ifdef REGCONTENT_AUTO_SCAN_EN
         auto_q     <= auto_d;
         relaunch_q <= relaunch_d;
`endif
      end
   end

   assign avs_readdata = rdata_q;
   assign rf_req       = rf_req_q;
   assign rf_idx       = idx_q;
   assign irq          = irq_q;

endmodule

// File: tb/tb_regcontent_read_sequencer.sv
// tb_regcontent_read_sequencer
//   Randomised bench for regcontent_read_sequencer (IDX_W=6, TIMEOUT=4).
//   A small reference model tracks DATA/valid/timeout_err/seq/IEN/index from
//   the register-level rules; every host-visible value is compared with it.
module tb_regcontent_read_sequencer;

   localparam int IDX_W   = 6;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 4;
   localparam int NIDX    = 1 << IDX_W;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [1:0]        avs_address;
   logic              avs_read;
   logic              avs_write;
   logic [31:0]       avs_writedata;
   logic [31:0]       avs_readdata;
   logic              rf_req;
   logic [IDX_W-1:0]  rf_idx;
   logic              rf_ack;
   logic [DATA_W-1:0] rf_data;
   logic              irq;

   regcontent_read_sequencer #(
      .IDX_W   (IDX_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .avs_address   (avs_address),
      .avs_read      (avs_read),
      .avs_write     (avs_write),
      .avs_writedata (avs_writedata),
      .avs_readdata  (avs_readdata),
      .rf_req        (rf_req),
      .rf_idx        (rf_idx),
      .rf_ack        (rf_ack),
      .rf_data       (rf_data),
      .irq           (irq)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model
   logic [31:0] m_data;
   logic        m_valid, m_terr, m_ien;
   int          m_seq, m_idx;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [1:0] addr, input logic [31:0] wd);
      avs_address   = addr;
      avs_writedata = wd;
      avs_write     = 1'b1;
      tick();
      avs_write     = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] addr, output logic [31:0] rd);
      avs_address = addr;
      avs_read    = 1'b1;
      tick();
      rd          = avs_readdata;
      avs_read    = 1'b0;
   endtask

   function automatic logic [31:0] exp_status(input logic busy);
      logic [31:0] s;
      s = 32'(m_seq % 256) << 16;
      s = s | (32'(m_terr) << 2) | (32'(m_valid) << 1) | 32'(busy);
      return s;
   endfunction

   task automatic model_reset();
      m_data  = '0;
      m_valid = 1'b0;
      m_terr  = 1'b0;
      m_ien   = 1'b0;
      m_seq   = 0;
      m_idx   = 0;
   endtask

   task automatic check_regs();
      logic [31:0] rd;
      bus_read(2'd0, rd);
      check_val("data", rd, m_data);
      bus_read(2'd2, rd);
      check_val("status", rd, exp_status(1'b0));
      bus_read(2'd3, rd);
      check_val("ien", rd, 32'(m_ien));
      check_val("irq", 32'(irq), 32'(m_ien & (m_valid | m_terr)));
   endtask

   // One start/response exchange. ack_at: REQ cycle carrying rf_ack
   // (> TIMEOUT means never). op at REQ cycle 1: 0 none, 1 start while busy,
   // 2 DATA read while busy. w1c: clear valid in the ack cycle.
   task automatic run_txn(input int tno, input int idx, input int ack_at, input logic [31:0] val,
                          input int op, input bit w1c);
      logic [31:0] old_data;
      int          cnt;
      bit          rd_issued;
      old_data = m_data;
      bus_write(2'd1, 32'h8000_0000 | 32'(idx));
      m_idx   = idx % NIDX;
      m_valid = 1'b0;
      m_terr  = 1'b0;
      cnt     = 0;
      while (rf_req === 1'b1 && cnt < 64) begin
         cnt++;
         rd_issued = 1'b0;
         check_val("rf_idx_busy", 32'(rf_idx), 32'(m_idx));
         if (cnt == ack_at) begin
            rf_ack  = 1'b1;
            rf_data = val;
            if (w1c) begin
               avs_address   = 2'd2;
               avs_writedata = 32'h2;
               avs_write     = 1'b1;
            end
         end else if (cnt == 1 && op == 1) begin
            avs_address   = 2'd1;
            avs_writedata = 32'h8000_0000 | 32'((idx + 4) % NIDX);
            avs_write     = 1'b1;
         end else if (cnt == 1 && op == 2) begin
            avs_address = 2'd0;
            avs_read    = 1'b1;
            rd_issued   = 1'b1;
         end
         tick();
         if (rd_issued) check_val("data_while_busy", avs_readdata, old_data);
         rf_ack    = 1'b0;
         avs_write = 1'b0;
         avs_read  = 1'b0;
         rf_data   = $urandom;
      end
      check_val("req_cycles", 32'(cnt), 32'((ack_at <= TIMEOUT) ? ack_at : TIMEOUT));
      if (ack_at <= TIMEOUT) begin
         m_data  = val;
         m_valid = 1'b1;
         m_seq   = m_seq + 1;
      end else begin
         m_terr  = 1'b1;
      end
      // irq reflects the new flags only one cycle after they change;
      // an ack outside REQ in that cycle must be ignored.
      check_val("irq_lag0", 32'(irq), 32'h0);
      rf_ack  = 1'b1;
      rf_data = $urandom;
      tick();
      rf_ack  = 1'b0;
      check_val("irq_lag1", 32'(irq), 32'(m_ien & (m_valid | m_terr)));
      $display("txn %0d idx=%0d ack_at=%0d op=%0d w1c=%0d req_cycles=%0d data=%h seq=%0d",
               tno, idx, ack_at, op, w1c, cnt, m_data, m_seq % 256);
      check_regs();
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog timer expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic [31:0] wd;
      int          seq0, gap, d, op;
      bit          w;

      reset_n       = 1'b0;
      avs_address   = '0;
      avs_read      = 1'b0;
      avs_write     = 1'b0;
      avs_writedata = '0;
      rf_ack        = 1'b0;
      rf_data       = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #2;
      check_val("rst_rf_req", 32'(rf_req), 32'h0);
      check_val("rst_rf_idx", 32'(rf_idx), 32'h0);
      check_val("rst_irq", 32'(irq), 32'h0);
      check_val("rst_readdata", avs_readdata, 32'h0);
      reset_n = 1'b1;
      tick();
      check_regs();

      // single shot with start-while-busy (0x8000_0009) mid-REQ
      avs_address   = 2'd1;
      avs_writedata = 32'h8000_0005;
      avs_write     = 1'b1;
      tick();
      avs_write = 1'b0;
      m_idx = 5; m_valid = 1'b0; m_terr = 1'b0;
      check_val("single_busy", 32'(rf_req), 32'h1);
      check_val("single_idx", 32'(rf_idx), 32'd5);
      bus_write(2'd1, 32'h8000_0009);
      check_val("single_idx_kept", 32'(rf_idx), 32'd5);
      rf_ack  = 1'b1;
      rf_data = 32'hDEAD_BEEF;
      tick();
      rf_ack  = 1'b0;
      m_data = 32'hDEAD_BEEF; m_valid = 1'b1; m_seq = 1;
      check_val("single_req_drop", 32'(rf_req), 32'h0);
      repeat (3) tick();
      check_val("single_no_restart", 32'(rf_req), 32'h0);
      check_regs();

      // timeout with no ack, ack exactly at the timeout cycle, W1C vs capture
      run_txn(0, 7, TIMEOUT + 1, 32'h1111_2222, 2, 1'b0);
      run_txn(1, 2, TIMEOUT, 32'h3333_4444, 0, 1'b0);
      bus_write(2'd3, 32'h1);
      m_ien = 1'b1;
      run_txn(2, 3, 2, 32'h5555_6666, 0, 1'b1);

      // CTRL write without start only updates the index; bit30 handling
`ifdef REGCONTENT_AUTO_SCAN_EN
      bus_write(2'd1, 32'h4000_0007);
      bus_read(2'd1, rd);
      check_val("ctrl_auto_rw", rd, 32'h4000_0007);
      bus_write(2'd1, 32'h0000_0007);
`else
      bus_write(2'd1, 32'h4000_0007);
      bus_read(2'd1, rd);
      check_val("ctrl_bit30_ignored", rd, 32'h0000_0007);
`endif

      // randomised phase
      for (int t = 3; t < 303; t++) begin
         if ($urandom_range(0, 3) == 0) begin
            w = 1'($urandom_range(0, 1));
            bus_write(2'd3, 32'(w));
            m_ien = w;
         end
         if ($urandom_range(0, 3) == 0) begin
            wd = $urandom;
            bus_write(2'd2, wd);
            if (wd[1]) m_valid = 1'b0;
            if (wd[2]) m_terr  = 1'b0;
         end
         if ($urandom_range(0, 3) == 0) begin
            d = $urandom_range(0, NIDX - 1);
            bus_write(2'd1, 32'(d));
            m_idx = d;
            bus_read(2'd1, rd);
            check_val("ctrl_idx", rd, 32'(m_idx));
         end
         d  = $urandom_range(1, TIMEOUT + 2);
         op = (d > 1) ? $urandom_range(0, 2) : 0;
         w  = (d <= TIMEOUT) ? 1'($urandom_range(0, 1)) : 1'b0;
         run_txn(t, $urandom_range(0, NIDX - 1), d, $urandom, op, w);
      end

      // 256 captures bring seq back to where it started
      seq0 = m_seq % 256;
      for (int t = 0; t < 256; t++) begin
         run_txn(303 + t, $urandom_range(0, NIDX - 1), 1, $urandom, 0, 1'b0);
      end
      bus_read(2'd2, rd);
      check_val("seq_wrap", 32'(rd[23:16]), 32'(seq0));

`ifdef REGCONTENT_AUTO_SCAN_EN
      // auto scan from the top index: wraps to 0, one idle cycle between requests
      bus_write(2'd1, 32'hC000_0000 | 32'(NIDX - 1));
      m_valid = 1'b0; m_terr = 1'b0;
      for (int k = 0; k < 3; k++) begin
         gap = 0;
         while (rf_req !== 1'b1 && gap < 20) begin
            gap++;
            tick();
         end
         check_val("auto_gap", 32'(gap), 32'((k == 0) ? 0 : 1));
         check_val("auto_idx", 32'(rf_idx), 32'((NIDX - 1 + k) % NIDX));
         if (k == 2) begin
            bus_write(2'd1, 32'h0);
            check_val("auto_still_busy", 32'(rf_req), 32'h1);
         end
         wd      = $urandom;
         rf_ack  = 1'b1;
         rf_data = wd;
         tick();
         rf_ack  = 1'b0;
         m_data  = wd;
         m_valid = 1'b1;
         m_seq   = m_seq + 1;
         $display("auto txn %0d idx=%0d gap=%0d data=%h", k, (NIDX - 1 + k) % NIDX, gap, wd);
      end
      m_idx = (NIDX - 1 + 3) % NIDX;
      gap = 0;
      for (int k = 0; k < 6; k++) begin
         if (rf_req === 1'b1) gap++;
         tick();
      end
      check_val("auto_stopped", 32'(gap), 32'h0);
      bus_read(2'd1, rd);
      check_val("auto_ctrl", rd, 32'(m_idx));
      check_regs();
`endif

      // asynchronous reset in the middle of a request
      bus_write(2'd1, 32'h8000_0011);
      tick();
      check_val("prereset_busy", 32'(rf_req), 32'h1);
      #2;
      reset_n = 1'b0;
      #1;
      check_val("async_rf_req", 32'(rf_req), 32'h0);
      check_val("async_irq", 32'(irq), 32'h0);
      check_val("async_readdata", avs_readdata, 32'h0);
      #2;
      reset_n = 1'b1;
      model_reset();
      tick();
      bus_read(2'd1, rd);
      check_val("reset_ctrl", rd, 32'h0);
      check_regs();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
